// File: rtl/alu_pkg.sv
// Shared types for the nibble-serial ALU sequencer: opcode encodings,
// alu control word, controller states and the command class decode.
package alu_pkg;

    // Low four command bits select the operation inside the alu.
    // op[3] inverts operand B (arith) or the result (XOR/XNOR).
    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b1000,
        OP_XOR   = 4'b0001,
        OP_XNOR  = 4'b1001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0110,
        OP_RSHFT = 4'b0111
    } AluCmd;

    // Full 5-bit request encodings; bit4 is the initial carry for the
    // arith class and the fill bit for RSHFT.
    typedef enum logic [4:0] {
        CTRL_ADD    = 5'b00000,
        CTRL_ADDC   = 5'b10000,
        CTRL_SUB    = 5'b11000,
        CTRL_COMP   = 5'b01000,
        CTRL_XOR    = 5'b00001,
        CTRL_XNOR   = 5'b01001,
        CTRL_AND    = 5'b00010,
        CTRL_OR     = 5'b00110,
        CTRL_RSHFT  = 5'b00111,
        CTRL_RSHFT1 = 5'b10111
    } AluCtrl;

    // Control word presented to the 4-bit alu each cycle.
    typedef struct packed {
        logic       cin;
        logic [3:0] op;
    } AluCtrlInternal;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } SeqState;

    typedef enum logic [1:0] {
        CLS_ARITH = 2'd0,
        CLS_SHIFT = 2'd1,
        CLS_LOGIC = 2'd2
    } AluClass;

    function automatic AluClass alu_class(input logic [3:0] op);
        if (!op[2] && (op[1:0] == 2'b00)) return CLS_ARITH;
        else if (op[1:0] == 2'b11)       return CLS_SHIFT;
        else                             return CLS_LOGIC;
    endfunction

endpackage

// File: rtl/alu_nibble_seq_if.sv
// Request/response handshake bundle between issue stage, sequencer and
// result consumer.
interface alu_nibble_seq_if #(
    parameter int W = 16
);
    logic         req_valid;
    logic         req_ready;
    logic [4:0]   req_cmd;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_res;
    logic         resp_carry;
    logic         resp_zero;

    modport master (
        output req_valid, req_cmd, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_res, resp_carry, resp_zero
    );

    modport slave (
        input  req_valid, req_cmd, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_res, resp_carry, resp_zero
    );
endinterface

// File: rtl/alu_nibble_seq_alu.sv
// 4-bit combinational alu slice: add/subtract with carry, logic ops and a
// one-bit right shift with caller-supplied shift-in.
module alu_nibble_seq_alu
    import alu_pkg::*;
(
    input  logic [3:0]     i_d1,
    input  logic [3:0]     i_d2,
    input  AluCtrlInternal i_ctrl,
    output logic [3:0]     o_res,
    output logic           o_carry
);

    logic [3:0] w_d2x;
    logic [4:0] w_sum;

    // Operation select; carry out is only meaningful for arith and shift.
    always_comb begin
        w_d2x   = i_ctrl.op[3] ? ~i_d2 : i_d2;
        w_sum   = {1'b0, i_d1} + {1'b0, w_d2x} + {4'b0000, i_ctrl.cin};
        o_res   = 4'h0;
        o_carry = 1'b0;
        case (alu_class(i_ctrl.op))
            CLS_ARITH: begin
                o_res   = w_sum[3:0];
                o_carry = w_sum[4];
            end
            CLS_SHIFT: begin
                o_res   = {i_ctrl.cin, i_d2[3:1]};
                o_carry = i_d2[0];
            end
            default: begin
                case (i_ctrl.op[1:0])
                    2'b01:   o_res = (i_d1 ^ i_d2) ^ {4{i_ctrl.op[3]}};
                    2'b10:   o_res = i_ctrl.op[2] ? (i_d1 | i_d2) : (i_d1 & i_d2);
                    default: o_res = i_d1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_nibble_seq.sv
// Nibble-serial W-bit ALU sequencer built around one shared 4-bit alu.
//
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   RUN   | processing nibble r_idx, LSB nibble first
//   DONE  | response held until resp_ready
module alu_nibble_seq
    import alu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_nibble_seq_if.slave  bus
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

    SeqState         r_state;
    logic [IDXW-1:0] r_idx;
    logic [4:0]      r_cmd;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic            r_zero_acc;
    logic [W-1:0]    r_acc;
    logic            r_req_ready;
    logic            r_resp_valid;
    logic [W-1:0]    r_resp_res;
    logic            r_resp_carry;
    logic            r_resp_zero;

    AluClass         w_cls;
    AluCtrlInternal  w_ctrl;
    logic [3:0]      w_d1;
    logic [3:0]      w_d2;
    logic            w_shift_in;
    logic [NIBBLES-1:0] w_fill;
    logic [3:0]      w_alu_res;
    logic            w_alu_cout;
    logic [W-1:0]    w_acc_next;
    logic            w_zero_next;
    logic            w_final_carry;

    assign w_cls = alu_class(r_cmd[3:0]);

    // Shift-in per nibble: next nibble's LSB of B, or the fill bit on top.
    for (genvar g = 0; g < NIBBLES; g++) begin : g_fill
        if (g < NIBBLES - 1) begin : g_mid
            assign w_fill[g] = r_b[4*g+4];
        end else begin : g_top
            assign w_fill[g] = r_cmd[4];
        end
    end

    // Select the operand nibbles for the current index.
    always_comb begin
        w_d1       = 4'h0;
        w_d2       = 4'h0;
        w_shift_in = 1'b0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_d1       = r_a[4*k +: 4];
                w_d2       = r_b[4*k +: 4];
                w_shift_in = w_fill[k];
            end
        end
    end

    // Build the alu control word; logic ops always see cin = 0.
    always_comb begin
        w_ctrl.op = r_cmd[3:0];
        case (w_cls)
            CLS_ARITH: w_ctrl.cin = r_carry;
            CLS_SHIFT: w_ctrl.cin = w_shift_in;
            default:   w_ctrl.cin = 1'b0;
        endcase
    end

    alu_nibble_seq_alu u_alu (
        .i_d1    (w_d1),
        .i_d2    (w_d2),
        .i_ctrl  (w_ctrl),
        .o_res   (w_alu_res),
        .o_carry (w_alu_cout)
    );

    // Merge the fresh result nibble into the working result and flags.
    always_comb begin
        w_acc_next = r_acc;
        for (int k = 0; k < NIBBLES; k++) begin
            if (r_idx == IDXW'(k)) w_acc_next[4*k +: 4] = w_alu_res;
        end
        w_zero_next = r_zero_acc & (w_alu_res == 4'h0);
        case (w_cls)
            CLS_ARITH: w_final_carry = w_alu_cout;
            CLS_SHIFT: w_final_carry = r_b[0];
            default:   w_final_carry = 1'b0;
        endcase
    end

    // Sequencer FSM with its datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_cmd        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_carry      <= 1'b0;
            r_zero_acc   <= 1'b0;
            r_acc        <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_res   <= '0;
            r_resp_carry <= 1'b0;
            r_resp_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_state     <= RUN;
                        r_req_ready <= 1'b0;
                        r_cmd       <= bus.req_cmd;
                        r_a         <= bus.req_a;
                        r_b         <= bus.req_b;
                        r_idx       <= '0;
                        r_carry     <= (alu_class(bus.req_cmd[3:0]) == CLS_ARITH) & bus.req_cmd[4];
                        r_zero_acc  <= 1'b1;
                        r_acc       <= '0;
                    end
                end
                RUN: begin
                    r_acc      <= w_acc_next;
                    r_zero_acc <= w_zero_next;
                    if (w_cls == CLS_ARITH) r_carry <= w_alu_cout;
                    r_idx <= r_idx + IDXW'(1);
                    if (r_idx == IDX_LAST) begin
                        r_idx        <= '0;
                        r_state      <= DONE;
                        r_resp_valid <= 1'b1;
                        r_resp_res   <= w_acc_next;
                        r_resp_carry <= w_final_carry;
                        r_resp_zero  <= w_zero_next;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_res   = r_resp_res;
    assign bus.resp_carry = r_resp_carry;
    assign bus.resp_zero  = r_resp_zero;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq with NIBBLES = 4 (W = 16).
module tb_alu_nibble_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_nibble_seq_if #(.W(16)) bus ();

    alu_nibble_seq #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [4:0]  cmd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        carry;
        logic        zero;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [4:0] cmd, input logic [15:0] a, input logic [15:0] b,
                        input string name);
        @(negedge clk);
        bus.req_cmd   = cmd;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        check($sformatf("%s req_ready", name), {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    // Called just after the accept edge; returns cycles until resp_valid.
    task automatic wait_resp(output int lat);
        lat = 0;
        @(negedge clk);
        while (!bus.resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_resp();
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        send(v.cmd, v.a, v.b, v.name);
        wait_resp(lat);
        check($sformatf("%s latency", v.name), lat, 32'd4);
        check($sformatf("%s res", v.name), {16'b0, bus.resp_res}, {16'b0, v.res});
        check($sformatf("%s carry", v.name), {31'b0, bus.resp_carry}, {31'b0, v.carry});
        check($sformatf("%s zero", v.name), {31'b0, bus.resp_zero}, {31'b0, v.zero});
        release_resp();
        @(negedge clk);
        check($sformatf("%s idle valid", v.name), {31'b0, bus.resp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        vecs[0]  = '{"add",     CTRL_ADD,    16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0};
        vecs[1]  = '{"sub_neg", CTRL_SUB,    16'h1234, 16'h1235, 16'hFFFF, 1'b0, 1'b0};
        vecs[2]  = '{"sub_eq",  CTRL_SUB,    16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1};
        vecs[3]  = '{"comp_gt", CTRL_COMP,   16'h8000, 16'h7FFF, 16'h0000, 1'b1, 1'b1};
        vecs[4]  = '{"comp_lt", CTRL_COMP,   16'h7FFF, 16'h8000, 16'hFFFE, 1'b0, 1'b0};
        vecs[5]  = '{"comp_eq", CTRL_COMP,   16'h5A5A, 16'h5A5A, 16'hFFFF, 1'b0, 1'b0};
        vecs[6]  = '{"rshft0",  CTRL_RSHFT,  16'h0000, 16'h8421, 16'h4210, 1'b1, 1'b0};
        vecs[7]  = '{"rshft1",  CTRL_RSHFT1, 16'h0000, 16'h8421, 16'hC210, 1'b1, 1'b0};
        vecs[8]  = '{"and",     CTRL_AND,    16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0};
        vecs[9]  = '{"add_wrap",CTRL_ADD,    16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
        vecs[10] = '{"addc",    CTRL_ADDC,   16'h1234, 16'h0001, 16'h1236, 1'b0, 1'b0};
        vecs[11] = '{"or",      CTRL_OR,     16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0};
        vecs[12] = '{"xor",     CTRL_XOR,    16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
        vecs[13] = '{"xnor",    CTRL_XNOR,   16'h1234, 16'h1234, 16'hFFFF, 1'b0, 1'b0};
        vecs[14] = '{"rshft_a", CTRL_RSHFT1, 16'hFFFF, 16'h0002, 16'h8001, 1'b0, 1'b0};

        bus.req_valid  = 1'b0;
        bus.req_cmd    = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;

        #3;
        check("rst valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst res",   {16'b0, bus.resp_res},   32'd0);
        check("rst carry", {31'b0, bus.resp_carry}, 32'd0);
        check("rst zero",  {31'b0, bus.resp_zero},  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst req_ready", {31'b0, bus.req_ready}, 32'd1);

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // Backpressure: response held while a new request waits.
        send(CTRL_SUB, 16'h1234, 16'h1234, "bp1");
        wait_resp(lat);
        check("bp1 latency", lat, 32'd4);
        bus.req_cmd   = CTRL_ADD;
        bus.req_a     = 16'hFFFF;
        bus.req_b     = 16'hFFFF;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp hold valid", {31'b0, bus.resp_valid}, 32'd1);
            check("bp hold res",   {16'b0, bus.resp_res},   32'd0);
            check("bp hold carry", {31'b0, bus.resp_carry}, 32'd1);
            check("bp hold zero",  {31'b0, bus.resp_zero},  32'd1);
            check("bp req_ready",  {31'b0, bus.req_ready},  32'd0);
        end
        release_resp();
        @(negedge clk);
        check("bp idle req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("bp idle valid", {31'b0, bus.resp_valid}, 32'd0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        wait_resp(lat);
        check("bp2 latency", lat, 32'd4);
        check("bp2 res",   {16'b0, bus.resp_res},   32'h0000FFFE);
        check("bp2 carry", {31'b0, bus.resp_carry}, 32'd1);
        check("bp2 zero",  {31'b0, bus.resp_zero},  32'd0);
        release_resp();

        // Reset in the middle of RUN abandons the op.
        send(CTRL_ADD, 16'hFFFF, 16'h0001, "abort");
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst valid", {31'b0, bus.resp_valid}, 32'd0);
        check("mid rst res",   {16'b0, bus.resp_res},   32'd0);
        check("mid rst carry", {31'b0, bus.resp_carry}, 32'd0);
        check("mid rst zero",  {31'b0, bus.resp_zero},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post rst req_ready", {31'b0, bus.req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check("no partial resp", seen, 32'd0);
        run_vec('{"add_after_rst", CTRL_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
